// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the RAM access controller and its response FIFO.
package ram_ctrl_pkg;

    typedef enum logic {ST_INIT, ST_RUN} ctrl_state_t;

    localparam int RSP_FIFO_DEPTH = 2;
    localparam int RSP_CNT_W      = $clog2(RSP_FIFO_DEPTH + 1);
    localparam int RSP_PTR_W      = $clog2(RSP_FIFO_DEPTH);

endpackage

// File: rtl/rsp_fifo.sv
// Two-entry synchronous response FIFO; head is visible combinationally while not empty.
module rsp_fifo
    import ram_ctrl_pkg::*;
#(
    parameter int D_WIDTH = 8
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic [D_WIDTH-1:0]   push_data,
    input  logic                 pop,
    output logic [D_WIDTH-1:0]   head,
    output logic                 full,
    output logic                 empty,
    output logic [RSP_CNT_W-1:0] count
);

    logic [D_WIDTH-1:0]        r_mem [RSP_FIFO_DEPTH];
    logic [RSP_PTR_W-1:0]      r_wr_ptr;
    logic [RSP_PTR_W-1:0]      r_rd_ptr;
    logic [RSP_CNT_W-1:0]      r_count;
    logic                      w_push_ok;
    logic                      w_pop_ok;
    logic [RSP_FIFO_DEPTH-1:0] w_entry_we;

    assign empty     = (r_count == '0);
    assign full      = (r_count == RSP_CNT_W'(RSP_FIFO_DEPTH));
    assign w_pop_ok  = pop && !empty;
    // A push into a full FIFO is legal only when the head leaves in the same cycle.
    assign w_push_ok = push && (!full || w_pop_ok);
    assign head      = r_mem[r_rd_ptr];
    assign count     = r_count;

    generate
        for (genvar gi = 0; gi < RSP_FIFO_DEPTH; gi++) begin : g_entry_we
            assign w_entry_we[gi] = w_push_ok && (r_wr_ptr == RSP_PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RSP_FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < RSP_FIFO_DEPTH; i++) begin
                if (w_entry_we[i]) begin
                    r_mem[i] <= push_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + RSP_PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + RSP_PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + RSP_CNT_W'(1);
                2'b01:   r_count <= r_count - RSP_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ram_access_ctrl.sv
// Initiator side of a 1-cycle-latency RAM: fills memory after reset/init_start, then turns
// a valid/ready request stream into RAM strobes and returns read data on a response stream.
module ram_access_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int                 A_WIDTH    = 4,
    parameter int                 D_WIDTH    = 8,
    parameter logic [D_WIDTH-1:0] INIT_VALUE = '0,
    parameter int                 RSP_DEPTH  = RSP_FIFO_DEPTH
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               init_start,
    output logic               init_done,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [A_WIDTH-1:0] req_addr,
    input  logic [D_WIDTH-1:0] req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [D_WIDTH-1:0] rsp_data,
    output logic               ram_write_en,
    output logic [A_WIDTH-1:0] ram_write_addr,
    output logic [D_WIDTH-1:0] ram_write_data,
    output logic               ram_read_en,
    output logic [A_WIDTH-1:0] ram_read_addr,
    input  logic [D_WIDTH-1:0] ram_read_data
);

    ctrl_state_t          r_state;
    ctrl_state_t          w_state_next;
    logic [A_WIDTH:0]     r_cnt;
    logic [A_WIDTH:0]     w_cnt_next;
    logic [A_WIDTH:0]     w_cnt_inc;
    logic                 r_init_pending;
    logic                 w_init_pending_next;
    logic                 r_inflight;
    logic                 w_inflight_next;

    logic                 w_fill_we;
    logic                 w_req_ready;
    logic                 w_req_hs;
    logic                 w_wr_hs;
    logic                 w_rd_hs;
    logic                 w_pop;
    logic                 w_fifo_full;
    logic                 w_fifo_empty;
    logic [RSP_CNT_W-1:0] w_fifo_count;
    logic [D_WIDTH-1:0]   w_fifo_head;
    logic [RSP_CNT_W:0]   w_occupancy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_INIT;
            r_cnt          <= '0;
            r_init_pending <= 1'b0;
            r_inflight     <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_init_pending <= w_init_pending_next;
            r_inflight     <= w_inflight_next;
        end
    end

    // The head popped this cycle frees its slot, so it is credited back; this keeps
    // back-to-back reads at one per cycle while the consumer is ready.
    always_comb begin
        w_pop       = !w_fifo_empty && rsp_ready;
        w_occupancy = {1'b0, w_fifo_count} + (RSP_CNT_W + 1)'(r_inflight)
                      - (RSP_CNT_W + 1)'(w_pop);
        w_req_ready = (r_state == ST_RUN) && !r_init_pending
                      && (w_occupancy < (RSP_CNT_W + 1)'(RSP_DEPTH));
        w_req_hs    = req_valid && w_req_ready;
        w_wr_hs     = w_req_hs && req_we;
        w_rd_hs     = w_req_hs && !req_we;
        w_cnt_inc   = r_cnt + (A_WIDTH + 1)'(1);
    end

    always_comb begin
        w_state_next        = r_state;
        w_cnt_next          = r_cnt;
        w_init_pending_next = r_init_pending;
        w_inflight_next     = w_rd_hs;
        case (r_state)
            ST_INIT: begin
                w_cnt_next = w_cnt_inc;
                if (w_cnt_inc[A_WIDTH]) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (init_start || r_init_pending) begin
                    if (!r_inflight && !w_req_hs) begin
                        w_state_next        = ST_INIT;
                        w_cnt_next          = '0;
                        w_init_pending_next = 1'b0;
                    end else begin
                        w_init_pending_next = 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = ST_INIT;
                w_cnt_next   = '0;
            end
        endcase
    end

    // The fill strobe is masked while reset is held so every output reads 0 during reset.
    always_comb begin
        w_fill_we      = (r_state == ST_INIT) && !rst;
        init_done      = (r_state == ST_RUN);
        req_ready      = w_req_ready;
        ram_write_en   = w_fill_we || w_wr_hs;
        ram_write_addr = '0;
        ram_write_data = '0;
        if (w_fill_we) begin
            ram_write_addr = r_cnt[A_WIDTH-1:0];
            ram_write_data = INIT_VALUE;
        end else if (w_wr_hs) begin
            ram_write_addr = req_addr;
            ram_write_data = req_wdata;
        end
        ram_read_en   = w_rd_hs;
        ram_read_addr = w_rd_hs ? req_addr : '0;
        rsp_valid     = !w_fifo_empty;
        rsp_data      = w_fifo_head;
    end

    rsp_fifo #(
        .D_WIDTH (D_WIDTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (r_inflight),
        .push_data (ram_read_data),
        .pop       (w_pop),
        .head      (w_fifo_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(r_inflight && w_fifo_full && !w_pop));

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl with a behavioural 1-cycle registered-read RAM.
module tb_ram_access_ctrl;

    logic       clk;
    logic       rst;
    logic       init_start;
    logic       init_done;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [3:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       ram_write_en;
    logic [3:0] ram_write_addr;
    logic [7:0] ram_write_data;
    logic       ram_read_en;
    logic [3:0] ram_read_addr;
    logic [7:0] ram_read_data;

    int         n_compared   = 0;
    int         n_mismatched = 0;
    int         cyc          = 0;
    logic [7:0] sb_q [$];
    int         pop_cyc [$];
    logic [7:0] sh_mem [16];
    logic [7:0] ram_mem [16];

    ram_access_ctrl #(
        .A_WIDTH    (4),
        .D_WIDTH    (8),
        .INIT_VALUE (8'h00),
        .RSP_DEPTH  (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .init_start     (init_start),
        .init_done      (init_done),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .ram_write_en   (ram_write_en),
        .ram_write_addr (ram_write_addr),
        .ram_write_data (ram_write_data),
        .ram_read_en    (ram_read_en),
        .ram_read_addr  (ram_read_addr),
        .ram_read_data  (ram_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM: registered read, read_data returns to zero when no read was issued.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_read_data <= '0;
        end else begin
            if (ram_write_en) ram_mem[ram_write_addr] <= ram_write_data;
            ram_read_data <= ram_read_en ? ram_mem[ram_read_addr] : 8'h00;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h required 0x%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic fill_shadow();
        for (int i = 0; i < 16; i++) sh_mem[i] = 8'h00;
    endtask

    task automatic send(input logic we, input logic [3:0] addr, input logic [7:0] data, output int stalls);
        stalls = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        #1;
        while (!req_ready && stalls < 100) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (!req_ready) begin
            check_value("req_accept", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
        end else begin
            if (we) sh_mem[addr] = data;
            else    sb_q.push_back(sh_mem[addr]);
            $display("req %s addr=%0d data=%02h stalls=%0d cyc=%0d", we ? "WR" : "RD", addr, data, stalls, cyc);
            @(posedge clk);
            #1;
            req_valid = 1'b0;
        end
    endtask

    task automatic wait_init(input logic chk_ready);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (init_done) break;
            if (chk_ready) check_value("pend_ready", 32'(req_ready), 32'd0);
        end
        check_value("init_done", 32'(init_done), 32'd1);
        fill_shadow();
    endtask

    always begin
        @(negedge clk);
        #2;
        if (!rst && rsp_valid && rsp_ready) begin
            check_value("rsp_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                logic [7:0] exp_data;
                exp_data = sb_q.pop_front();
                check_value("rsp_data", 32'(rsp_data), 32'(exp_data));
                pop_cyc.push_back(cyc);
                $display("rsp data=%02h exp=%02h cyc=%0d", rsp_data, exp_data, cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st;
        int n;
        rst        = 1'b1;
        init_start = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = 1'b1;

        // Reset state and initial fill
        repeat (2) @(negedge clk);
        #1;
        check_value("rst_outs", 32'({ram_write_en, ram_read_en, req_ready, rsp_valid, init_done}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) begin
            check_value("fill", 32'({ram_write_en, init_done, req_ready, ram_write_addr, ram_write_data}),
                        32'({1'b1, 1'b0, 1'b0, 4'(i), 8'h00}));
            @(negedge clk);
            #1;
        end
        check_value("done_c17", 32'({init_done, ram_write_en}), 32'b10);
        fill_shadow();
        for (int i = 0; i < 16; i++) send(1'b0, 4'(i), 8'h00, st);
        repeat (4) @(negedge clk);

        // Write then read same address on the next cycle; response 2 cycles after handshake
        send(1'b1, 4'd3, 8'hA5, st);
        send(1'b0, 4'd3, 8'h00, st);
        @(negedge clk);
        #1;
        check_value("lat_c1", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        check_value("lat_c2", 32'(rsp_valid), 32'd1);
        repeat (3) @(negedge clk);

        // Backpressure: two accepts, then stall until the consumer is ready
        send(1'b1, 4'd1, 8'h11, st);
        send(1'b1, 4'd2, 8'h22, st);
        send(1'b1, 4'd3, 8'h33, st);
        rsp_ready = 1'b0;
        send(1'b0, 4'd1, 8'h00, st);
        check_value("bp_acc1", 32'(st), 32'd0);
        send(1'b0, 4'd2, 8'h00, st);
        check_value("bp_acc2", 32'(st), 32'd0);
        fork
            send(1'b0, 4'd3, 8'h00, st);
            begin
                repeat (3) begin
                    @(negedge clk);
                    #1;
                    check_value("bp_full", 32'(req_ready), 32'd0);
                end
                @(negedge clk);
                rsp_ready = 1'b1;
            end
        join
        repeat (5) @(negedge clk);
        check_value("bp_drain", 32'(sb_q.size()), 32'd0);

        // Continuous reads at full throughput
        for (int i = 0; i < 8; i++) begin
            send(1'b0, 4'(15 - i), 8'h00, st);
            check_value("thru_stall", 32'(st), 32'd0);
        end
        repeat (5) @(negedge clk);
        n = pop_cyc.size();
        for (int k = 1; k < 8; k++) check_value("thru_rsp", 32'(pop_cyc[n-8+k] - pop_cyc[n-8+k-1]), 32'd1);

        // Reset during INIT at cnt=7
        @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        #1;
        check_value("fill_7", 32'({ram_write_en, ram_write_addr}), 32'({1'b1, 4'd7}));
        rst = 1'b1;
        #1;
        check_value("rst_mid", 32'({ram_write_en, ram_write_addr, ram_read_en, req_ready, init_done, rsp_valid}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_value("refill_0", 32'({ram_write_en, ram_write_addr}), 32'({1'b1, 4'd0}));
        wait_init(1'b0);

        // Reset with a read in flight: its response is discarded
        send(1'b1, 4'd4, 8'h44, st);
        send(1'b0, 4'd4, 8'h00, st);
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            #1;
            check_value("rst_norsp", 32'(rsp_valid), 32'd0);
        end
        wait_init(1'b0);

        // init_start with a read in flight: response delivered, then refill
        send(1'b1, 4'd5, 8'h5A, st);
        send(1'b0, 4'd5, 8'h00, st);
        @(negedge clk);
        init_start = 1'b1;
        @(negedge clk);
        init_start = 1'b0;
        #1;
        check_value("pend_blk", 32'(req_ready), 32'd0);
        wait_init(1'b1);
        check_value("init_rsp", 32'(sb_q.size()), 32'd0);
        send(1'b0, 4'd5, 8'h00, st);
        send(1'b0, 4'd3, 8'h00, st);
        send(1'b0, 4'd15, 8'h00, st);
        repeat (5) @(negedge clk);
        check_value("final_drain", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
